// File: rtl/rgb_pkg.sv
// Shared state encoding and phase-index sizing for the RGB PWM colour-wheel cycler.
// No logic of its own; imported by rgb_pwm_cycler and pwm_channel.
package rgb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Width of the phase index; a two-channel wheel still needs one bit.
  function automatic int unsigned phase_w(input int unsigned channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One LED output: lit while duty exceeds the shared PWM counter, polarity applied.
// Latency 1 cycle (registered pin), no backpressure; reset drives the LED off.
module pwm_channel #(
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o
);

  logic led_q;
  logic led_d;

  // Strict compare keeps the top duty one cycle short of full-on.
  always_comb begin
    led_d = (duty_i > pwm_cnt_i) ? ~ACTIVE_LOW : ACTIVE_LOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= ACTIVE_LOW;
    end else begin
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/rgb_pwm_cycler.sv
// Colour-wheel PWM sequencer: channel p fades in while p-1 fades out; LEDs registered (1 cycle), no backpressure.
// Optional triangle brightness envelope scaling every duty when RGB_BREATHE_EN is defined.
module rgb_pwm_cycler
  import rgb_pkg::*;
#(
  parameter int TOP_BIT    = 22,
  parameter int PWM_BITS   = 8,
  parameter int CHANNELS   = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty_max,
  output logic [CHANNELS-1:0] led
);

  localparam int unsigned     PW     = phase_w(CHANNELS);
  localparam logic [PW-1:0]   LAST_P = PW'(CHANNELS - 1);

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [TOP_BIT-1:0]  pre_cnt_q, pre_cnt_d;
  logic [PW-1:0]       p_q, p_d, p_prev;
  logic [PWM_BITS-1:0] lvl_q, lvl_d;
  logic [PWM_BITS-1:0] fade_out;
  logic                step;
  logic                adv;

  logic [PWM_BITS-1:0] duty_raw [CHANNELS];
  logic [PWM_BITS-1:0] duty     [CHANNELS];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable)  state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_HOLD;
      ST_HOLD: if (enable)  state_d = ST_RUN;
      default:              state_d = ST_IDLE;
    endcase
  end

  // A step coinciding with enable falling is dropped: the freeze wins.
  always_comb begin
    step      = (state_q == ST_RUN) && (&pre_cnt_q);
    adv       = step && enable;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    pre_cnt_d = (state_q == ST_RUN) ? pre_cnt_q + 1'b1 : pre_cnt_q;
    p_d       = p_q;
    lvl_d     = lvl_q;
    if (adv) begin
      if (lvl_q >= duty_max) begin
        lvl_d = '0;
        p_d   = (p_q == LAST_P) ? '0 : p_q + 1'b1;
      end else begin
        lvl_d = lvl_q + 1'b1;
      end
    end
  end

  always_comb begin
    p_prev   = (p_q == '0) ? LAST_P : p_q - 1'b1;
    fade_out = (duty_max > lvl_q) ? duty_max - lvl_q : '0;
    for (int c = 0; c < CHANNELS; c++) begin
      duty_raw[c] = '0;
      if (state_q != ST_IDLE) begin
        if (PW'(c) == p_q) begin
          duty_raw[c] = lvl_q;
        end else if (PW'(c) == p_prev) begin
          duty_raw[c] = fade_out;
        end
      end
    end
  end

`ifdef RGB_BREATHE_EN
  logic [PWM_BITS-1:0] env_q, env_d;
  logic                env_up_q, env_up_d;

  // Triangle envelope, one count per accepted step, turning at the rails.
  always_comb begin
    env_d    = env_q;
    env_up_d = env_up_q;
    if (adv) begin
      if (env_up_q) begin
        if (&env_q) begin
          env_up_d = 1'b0;
          env_d    = env_q - 1'b1;
        end else begin
          env_d    = env_q + 1'b1;
        end
      end else begin
        if (env_q == '0) begin
          env_up_d = 1'b1;
          env_d    = env_q + 1'b1;
        end else begin
          env_d    = env_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      env_q    <= '0;
      env_up_q <= 1'b1;
    end else begin
      env_q    <= env_d;
      env_up_q <= env_up_d;
    end
  end

  always_comb begin
    logic [2*PWM_BITS-1:0] prod;
    prod = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      prod    = {{PWM_BITS{1'b0}}, duty_raw[c]} * {{PWM_BITS{1'b0}}, env_q};
      duty[c] = prod[2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      duty[c] = duty_raw[c];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pwm_cnt_q <= '0;
      pre_cnt_q <= '0;
      p_q       <= '0;
      lvl_q     <= '0;
    end else begin
      state_q   <= state_d;
      pwm_cnt_q <= pwm_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      p_q       <= p_d;
      lvl_q     <= lvl_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .ACTIVE_LOW (ACTIVE_LOW != 0)
    ) u_ch (
      .clk       (clk),
      .rst_n     (reset),
      .duty_i    (duty[c]),
      .pwm_cnt_i (pwm_cnt_q),
      .led_o     (led[c])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_cycler.sv
// Directed bench for rgb_pwm_cycler with TOP_BIT=2, PWM_BITS=3, CHANNELS=3, active-low LEDs.
// Cycle k counts rising edges since reset release; led after edge k reflects duties of cycle k-1.
module tb_rgb_pwm_cycler;
  import rgb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] duty_max;
  logic [2:0] led;

  int vectors = 0;
  int errors  = 0;

  rgb_pwm_cycler #(
    .TOP_BIT    (2),
    .PWM_BITS   (3),
    .CHANNELS   (3),
    .ACTIVE_LOW (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .duty_max (duty_max),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Active-low pin value for three duties against one PWM count.
  function automatic logic [2:0] exp_led(input int d0, input int d1, input int d2, input int pwm);
    logic [2:0] r;
    r[0] = (d0 > pwm) ? 1'b0 : 1'b1;
    r[1] = (d1 > pwm) ? 1'b0 : 1'b1;
    r[2] = (d2 > pwm) ? 1'b0 : 1'b1;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; duty_max = 3'd7;
    repeat (3) tick();
    vectors++;
    if (led !== 3'b111) begin errors++; $display("FAIL reset_led: led=%b expected=111", led); end
    reset = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      vectors++;
      if (led !== 3'b111) begin errors++; $display("FAIL idle_led k=%0d: led=%b expected=111", k, led); end
    end
    vectors++;
    if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL idle_state: state=%0d expected=%0d", dut.state_q, ST_IDLE); end
    vectors++;
    if (dut.pwm_cnt_q !== 3'd0) begin errors++; $display("FAIL pwm_cnt_40: got=%0d expected=0", dut.pwm_cnt_q); end
    vectors++;
    if (dut.pre_cnt_q !== 2'd0) begin errors++; $display("FAIL pre_cnt_idle: got=%0d expected=0", dut.pre_cnt_q); end
  endtask

  task automatic test_start();
    logic [2:0] e;
    enable = 1'b1;
    for (int k = 41; k <= 49; k++) begin
      int c;
      tick();
      c = k - 1;
      if (c == 40) e = 3'b111;
      else if (c <= 44) e = exp_led(0, 0, 7, c % 8);
      else e = exp_led(1, 0, 6, c % 8);
      vectors++;
      if (led !== e) begin errors++; $display("FAIL start_led k=%0d: led=%b expected=%b", k, led, e); end
      if (k == 44) begin
        vectors++;
        if (dut.lvl_q !== 3'd0) begin errors++; $display("FAIL first_step_early: lvl=%0d expected=0", dut.lvl_q); end
      end
      if (k == 45) begin
        vectors++;
        if (dut.lvl_q !== 3'd1) begin errors++; $display("FAIL first_step: lvl=%0d expected=1", dut.lvl_q); end
      end
    end
  endtask

  task automatic test_phase_wrap();
    logic [2:0] e;
    for (int k = 50; k <= 77; k++) begin
      int c;
      int l;
      tick();
      c = k - 1;
      if (c <= 72) begin
        l = (c - 41) / 4;
        e = exp_led(l, 0, 7 - l, c % 8);
      end else begin
        e = exp_led(7, 0, 0, c % 8);
      end
      vectors++;
      if (led !== e) begin errors++; $display("FAIL wrap_led k=%0d: led=%b expected=%b", k, led, e); end
      if (k == 72) begin
        vectors++;
        if (dut.p_q !== 2'd0 || dut.lvl_q !== 3'd7) begin
          errors++; $display("FAIL pre_wrap: p=%0d lvl=%0d expected p=0 lvl=7", dut.p_q, dut.lvl_q);
        end
      end
      if (k == 73) begin
        vectors++;
        if (dut.p_q !== 2'd1 || dut.lvl_q !== 3'd0) begin
          errors++; $display("FAIL post_wrap: p=%0d lvl=%0d expected p=1 lvl=0", dut.p_q, dut.lvl_q);
        end
      end
    end
  endtask

  task automatic test_freeze();
    logic [2:0] e;
    for (int k = 78; k <= 88; k++) begin
      int c;
      int l;
      tick();
      c = k - 1;
      l = (c - 73) / 4;
      e = exp_led(7 - l, l, 0, c % 8);
      vectors++;
      if (led !== e) begin errors++; $display("FAIL fade2_led k=%0d: led=%b expected=%b", k, led, e); end
    end
    // Cycle 88 carries a step; dropping enable now must suppress it.
    enable = 1'b0;
    for (int k = 89; k <= 152; k++) begin
      tick();
      e = exp_led(4, 3, 0, (k - 1) % 8);
      vectors++;
      if (led !== e) begin errors++; $display("FAIL hold_led k=%0d: led=%b expected=%b", k, led, e); end
      if (k == 89) begin
        vectors++;
        if (dut.state_q !== ST_HOLD || dut.lvl_q !== 3'd3) begin
          errors++; $display("FAIL enable_wins: state=%0d lvl=%0d expected state=%0d lvl=3", dut.state_q, dut.lvl_q, ST_HOLD);
        end
      end
    end
    vectors++;
    if (dut.p_q !== 2'd1 || dut.lvl_q !== 3'd3 || dut.pre_cnt_q !== 2'd0) begin
      errors++; $display("FAIL hold_frozen: p=%0d lvl=%0d pre=%0d expected p=1 lvl=3 pre=0", dut.p_q, dut.lvl_q, dut.pre_cnt_q);
    end
    enable = 1'b1;
    for (int k = 153; k <= 157; k++) begin
      tick();
      e = exp_led(4, 3, 0, (k - 1) % 8);
      vectors++;
      if (led !== e) begin errors++; $display("FAIL resume_led k=%0d: led=%b expected=%b", k, led, e); end
      if (k == 156) begin
        vectors++;
        if (dut.lvl_q !== 3'd3) begin errors++; $display("FAIL resume_early: lvl=%0d expected=3", dut.lvl_q); end
      end
      if (k == 157) begin
        vectors++;
        if (dut.lvl_q !== 3'd4) begin errors++; $display("FAIL resume_step: lvl=%0d expected=4", dut.lvl_q); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    for (int k = 158; k <= 161; k++) begin
      tick();
      e = exp_led(3, 4, 0, (k - 1) % 8);
      vectors++;
      if (led !== e) begin errors++; $display("FAIL fade3_led k=%0d: led=%b expected=%b", k, led, e); end
    end
    vectors++;
    if (led !== 3'b100) begin errors++; $display("FAIL lit_before_reset: led=%b expected=100", led); end
    reset = 1'b0;
    #1;
    vectors++;
    if (led !== 3'b111) begin errors++; $display("FAIL async_reset_led: led=%b expected=111", led); end
    vectors++;
    if (dut.state_q !== ST_IDLE || dut.p_q !== 2'd0 || dut.lvl_q !== 3'd0) begin
      errors++; $display("FAIL async_reset_state: state=%0d p=%0d lvl=%0d expected 0 0 0", dut.state_q, dut.p_q, dut.lvl_q);
    end
    enable = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vectors++;
      if (led !== 3'b111) begin errors++; $display("FAIL post_reset_led k=%0d: led=%b expected=111", k, led); end
    end
    vectors++;
    if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL post_reset_state: state=%0d expected=%0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_zero_peak();
    duty_max = 3'd0;
    enable   = 1'b1;
    for (int k = 9; k <= 25; k++) begin
      int ep;
      tick();
      vectors++;
      if (led !== 3'b111) begin errors++; $display("FAIL zero_led k=%0d: led=%b expected=111", k, led); end
      ep = -1;
      if (k == 12) ep = 0;
      if (k == 13) ep = 1;
      if (k == 16) ep = 1;
      if (k == 17) ep = 2;
      if (k == 21) ep = 0;
      if (k == 25) ep = 1;
      if (ep >= 0) begin
        vectors++;
        if (dut.p_q !== 2'(ep)) begin errors++; $display("FAIL zero_phase k=%0d: p=%0d expected=%0d", k, dut.p_q, ep); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_phase_wrap();
    test_freeze();
    test_reset_mid();
    test_zero_peak();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
